// File: rtl/systolic_ctrl_n.sv
// Schedules one NxN matrix multiply on an external output-stationary systolic array.
// Per-lane operand skew comes from a step counter rather than fixed delay chains.
module systolic_ctrl_n #(
    parameter int W       = 32,
    parameter int N       = 3,
    parameter int ARR_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    input  logic [W*N*N-1:0] i_arr_C,
    output logic [W*N-1:0]   o_a_feed,
    output logic [W*N-1:0]   o_b_feed,
    output logic             o_arr_clr,
    output logic             o_arr_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [W*N*N-1:0] o_C
);

    localparam int CW = $clog2(2*N + ARR_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2 + ARR_LAT);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W*N*N-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [W*N-1:0]   a_feed_q, a_feed_d, b_feed_q, b_feed_d;
    int               k;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        if (i_en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        a_d     = i_A;
                        b_d     = i_B;
                        cnt_d   = '0;
                        state_d = i_mode ? S_FEED : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt_d   = '0;
                    state_d = S_FEED;
                end
                S_FEED: begin
                    if (cnt_q == FEED_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        c_d     = i_arr_C;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Feeds are computed from the next state so the registered value lines up with step t.
    always_comb begin
        a_feed_d = '0;
        b_feed_d = '0;
        k        = 0;
        if (state_d == S_FEED) begin
            for (int l = 0; l < N; l++) begin
                k = int'(cnt_d) - l;
                if (k >= 0 && k < N) begin
                    a_feed_d[l*W +: W] = a_d[(l*N + k)*W +: W];
                    b_feed_d[l*W +: W] = b_d[(k*N + l)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            a_feed_q <= '0;
            b_feed_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            a_feed_q <= a_feed_d;
            b_feed_q <= b_feed_d;
        end
    end

    // A stall must silence the array in the same cycle, so i_en gates the registered values.
    assign o_a_feed  = i_en ? a_feed_q : '0;
    assign o_b_feed  = i_en ? b_feed_q : '0;
    assign o_arr_clr = i_en && (state_q == S_CLEAR);
    assign o_arr_en  = i_en && (state_q == S_CLEAR || state_q == S_FEED || state_q == S_DRAIN);
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = i_en && (state_q == S_DONE);
    assign o_C       = c_q;

endmodule

// File: tb/tb_systolic_ctrl_n.sv
// Bench for systolic_ctrl_n: three instances (N=3/LAT=1, N=2/LAT=3, N=4/LAT=3), each driving
// a behavioural output-stationary array, with expected results queued at start and popped at o_done.
module tb_systolic_ctrl_n;

    logic         clk;
    logic         rst;
    logic         en;
    logic         mode;
    logic [2:0]   start;
    logic [511:0] a_bus;
    logic [511:0] b_bus;

    logic [511:0] c_out   [3];
    logic [127:0] a_feed_v[3];
    logic [127:0] b_feed_v[3];
    logic [2:0]   done_v, busy_v, clr_v, arr_en_v;

    int           mat_a[4][4];
    int           mat_b[4][4];
    logic [511:0] prev_c[3];
    logic [511:0] exp_q[$];
    int           lat_q[$];
    int           n_total;
    int           n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NN  = (g == 0) ? 3 : ((g == 1) ? 2 : 4);
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [32*NN*NN-1:0] arr_c, oc;
        logic [32*NN-1:0]    af, bf;
        logic                clr_w, en_w, busy_w, done_w;
        logic [31:0]         acc [NN][NN];
        logic [31:0]         ar  [NN][NN];
        logic [31:0]         br  [NN][NN];
        logic [31:0]         a_in[NN][NN];
        logic [31:0]         b_in[NN][NN];

        systolic_ctrl_n #(.W(32), .N(NN), .ARR_LAT(LAT)) u_dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_en     (en),
            .i_start  (start[g]),
            .i_mode   (mode),
            .i_A      (a_bus[32*NN*NN-1:0]),
            .i_B      (b_bus[32*NN*NN-1:0]),
            .i_arr_C  (arr_c),
            .o_a_feed (af),
            .o_b_feed (bf),
            .o_arr_clr(clr_w),
            .o_arr_en (en_w),
            .o_busy   (busy_w),
            .o_done   (done_w),
            .o_C      (oc)
        );

        // A enters each row from the west and moves east; B enters each column from the north.
        always_comb begin
            for (int i = 0; i < NN; i++) begin
                a_in[i][0] = af[i*32 +: 32];
                b_in[0][i] = bf[i*32 +: 32];
                for (int j = 1; j < NN; j++) begin
                    a_in[i][j] = ar[i][j-1];
                    b_in[j][i] = br[j-1][i];
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < NN; i++) begin
                for (int j = 0; j < NN; j++) begin
                    if (rst) begin
                        acc[i][j] <= '0;
                        ar[i][j]  <= '0;
                        br[i][j]  <= '0;
                    end else if (en_w) begin
                        ar[i][j]  <= a_in[i][j];
                        br[i][j]  <= b_in[i][j];
                        acc[i][j] <= clr_w ? 32'd0 : acc[i][j] + a_in[i][j] * b_in[i][j];
                    end
                end
            end
        end

        always_comb begin
            for (int i = 0; i < NN; i++)
                for (int j = 0; j < NN; j++)
                    arr_c[(i*NN + j)*32 +: 32] = acc[i][j];
        end

        assign c_out[g]    = 512'(oc);
        assign a_feed_v[g] = 128'(af);
        assign b_feed_v[g] = 128'(bf);
        assign done_v[g]   = done_w;
        assign busy_v[g]   = busy_w;
        assign clr_v[g]    = clr_w;
        assign arr_en_v[g] = en_w;
    end

    function automatic int nOf(input int g);
        return (g == 0) ? 3 : ((g == 1) ? 2 : 4);
    endfunction

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [511:0] packMat(input int n, input bit is_a);
        logic [511:0] v;
        v = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                v[(r*n + c)*32 +: 32] = is_a ? mat_a[r][c] : mat_b[r][c];
        return v;
    endfunction

    // Lane r of A carries A(r, t-r); lane c of B carries B(t-c, c); zero outside the matrix.
    function automatic logic [127:0] expFeed(input int n, input int t, input bit is_a);
        logic [127:0] v;
        int           kk;
        v = '0;
        for (int l = 0; l < n; l++) begin
            kk = t - l;
            if (kk >= 0 && kk < n)
                v[l*32 +: 32] = is_a ? mat_a[l][kk] : mat_b[kk][l];
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_total++;
        if (got !== want)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        else
            n_pass++;
    endtask

    // One operation on instance g; optional stall window, start pokes while busy/DONE, and reset at cycle rst_at.
    task automatic applyStimulus(input int g, input bit md, input int stall_at, input int stall_len,
                                 input bit poke_start, input int rst_at);
        int           n, lat, j, p, t, busy_cnt, clr_cnt, exp_lat, got_lat, done_cnt, s;
        bit           seen;
        logic [511:0] exp_c, got_exp;
        n   = nOf(g);
        lat = latOf(g);
        exp_c = '0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = md ? int'(prev_c[g][(r*n + c)*32 +: 32]) : 0;
                for (int q = 0; q < n; q++) s += mat_a[r][q] * mat_b[q][c];
                exp_c[(r*n + c)*32 +: 32] = s;
            end
        end
        exp_lat = (md ? 0 : 1) + (2*n - 1) + (n - 1 + lat) + 1 + stall_len;
        exp_q.push_back(exp_c);
        lat_q.push_back(exp_lat);

        @(negedge clk);
        mode     = md;
        a_bus    = packMat(n, 1'b1);
        b_bus    = packMat(n, 1'b0);
        en       = 1'b1;
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;

        j = 0; p = 0; busy_cnt = 0; clr_cnt = 0; seen = 1'b0;
        while (!seen && j < 100) begin
            j++;
            en       = !(stall_len > 0 && j >= stall_at && j < stall_at + stall_len);
            start[g] = poke_start && (j == 2 || j == exp_lat);
            rst      = (rst_at > 0 && j == rst_at);
            @(negedge clk);
            if (busy_v[g]) busy_cnt++;
            if (clr_v[g])  clr_cnt++;
            if (!en) begin
                checkOutput("stall_quiet", 512'({a_feed_v[g], b_feed_v[g], arr_en_v[g], clr_v[g], done_v[g]}), '0);
            end else begin
                p++;
                t = p - 1 - (md ? 0 : 1);
                checkOutput("a_feed", 512'(a_feed_v[g]), 512'(expFeed(n, t, 1'b1)));
                checkOutput("b_feed", 512'(b_feed_v[g]), 512'(expFeed(n, t, 1'b0)));
            end
            if (done_v[g]) seen = 1'b1;
            if (rst_at > 0 && j == rst_at) break;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end

        got_exp = exp_q.pop_front();
        got_lat = lat_q.pop_front();

        if (rst_at > 0) begin
            @(posedge clk);
            #1 rst = 1'b0;
            start[g] = 1'b0;
            @(negedge clk);
            checkOutput("rst_feeds", 512'({a_feed_v[g], b_feed_v[g]}), '0);
            checkOutput("rst_ctrl", 512'({clr_v[g], arr_en_v[g], busy_v[g], done_v[g]}), '0);
            checkOutput("rst_result", c_out[g], '0);
            done_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done_v[g]) done_cnt++;
            end
            checkOutput("rst_no_done", 512'(done_cnt), '0);
            prev_c[g] = '0;
            return;
        end

        if (!seen) checkOutput("done_timeout", 512'(0), 512'(1));
        checkOutput("latency", 512'(j), 512'(got_lat));
        checkOutput("result", c_out[g], got_exp);
        checkOutput("busy_cycles", 512'(busy_cnt), 512'(got_lat));
        checkOutput("clr_cycles", 512'(clr_cnt), 512'(md ? 0 : 1));

        @(posedge clk);
        #1 start[g] = 1'b0;
        en = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_done", 512'({busy_v[g], done_v[g]}), '0);
        checkOutput("result_hold", c_out[g], got_exp);
        prev_c[g] = got_exp;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        en      = 1'b1;
        mode    = 1'b0;
        start   = '0;
        a_bus   = '0;
        b_bus   = '0;
        for (int g = 0; g < 3; g++) prev_c[g] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 512'(busy_v), '0);
        checkOutput("reset_done", 512'(done_v), '0);
        checkOutput("reset_ctrl", 512'({clr_v, arr_en_v}), '0);
        checkOutput("reset_feeds", 512'({a_feed_v[0], b_feed_v[0]}), '0);
        checkOutput("reset_result", c_out[0], '0);

        $display("[TB] skew pattern run");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mat_a[r][c] = 10*r + c + 1;
                mat_b[r][c] = 100 + 10*r + c + 1;
            end
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 0);

        $display("[TB] full multiply, clear then accumulate");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mat_a[r][c] = 2;
                mat_b[r][c] = 3;
            end
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("elem_18", 512'(c_out[0][4*32 +: 32]), 512'(18));
        applyStimulus(0, 1'b1, 0, 0, 1'b0, 0);
        checkOutput("elem_36", 512'(c_out[0][8*32 +: 32]), 512'(36));

        $display("[TB] stall mid-feed with ignored starts");
        applyStimulus(0, 1'b0, 4, 4, 1'b1, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 4);
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("post_rst_elem", 512'(c_out[0][0 +: 32]), 512'(18));

        $display("[TB] parameter sweep: identity times random");
        for (int g = 1; g < 3; g++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    mat_a[r][c] = (r == c) ? 1 : 0;
                    mat_b[r][c] = int'($urandom_range(0, 2000)) - 1000;
                end
            applyStimulus(g, 1'b0, 0, 0, 1'b0, 0);
            checkOutput("identity_eq_b", c_out[g], packMat(nOf(g), 1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
